branch_flag_unit: RTL

- Sits directly downstream of the 64-bit ALU in the execute stage. Consumes its 4-bit status {V,C,Z,N}.
- Holds the architectural NZCV flag register, written by flag-setting instructions (ADDS/SUBS/ANDS).
- Resolves unconditional, B.cond, CBZ and CBNZ branches.
- On a taken branch, drives a registered taken pulse and a multi-cycle pipeline flush. Branch and flag requests arriving during the flush are squashed.

---
 rtl/branch_flag_unit.sv | 112 +++++++++++
 1 files changed

// File: rtl/branch_flag_unit.sv
// Execute-stage flag register and branch resolver: holds NZCV, resolves B/B.cond/CBZ/CBNZ,
// and raises a registered taken pulse plus a multi-cycle flush that squashes younger requests.
//
// state | meaning
// RUN   | accepting flag writes and branches
// FLUSH | younger instructions being squashed; inputs ignored
module branch_flag_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [3:0] status_i,
  input  logic       set_flags_i,
  input  logic       br_valid_i,
  input  logic [1:0] br_type_i,
  input  logic [3:0] cond_i,
  output logic [3:0] flags_o,
  output logic       take_branch_o,
  output logic       flush_o
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t           state_q;
  logic [3:0]       flags_q;
  logic             take_q;
  logic             flush_q;
  logic [CNT_W-1:0] cnt_q;

  logic [3:0] eff_flags;
  logic       n_f, z_f, c_f, v_f;
  logic       cond_base;
  logic       cond_true;
  logic       br_taken;
  logic [3:0] flags_d;

  // A flag write in the same cycle as a B.cond is older, so its result is bypassed.
  always_comb begin
    eff_flags = set_flags_i ? status_i : flags_q;
    {v_f, c_f, z_f, n_f} = eff_flags;
    flags_d = set_flags_i ? status_i : flags_q;

    // Codes come in pairs: odd code is the inverse of the even one, except AL/NV.
    cond_base = 1'b1;
    case (cond_i[3:1])
      3'd0:    cond_base = z_f;
      3'd1:    cond_base = c_f;
      3'd2:    cond_base = n_f;
      3'd3:    cond_base = v_f;
      3'd4:    cond_base = c_f & ~z_f;
      3'd5:    cond_base = (n_f == v_f);
      3'd6:    cond_base = ~z_f & (n_f == v_f);
      default: cond_base = 1'b1;
    endcase
    cond_true = (cond_i[3:1] == 3'b111) ? 1'b1 : (cond_base ^ cond_i[0]);

    br_taken = 1'b0;
    case (br_type_i)
      2'b00: br_taken = 1'b1;
      2'b01: br_taken = cond_true;
      2'b10: br_taken = status_i[1];
      2'b11: br_taken = ~status_i[1];
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= RUN;
      flags_q <= 4'b0000;
      take_q  <= 1'b0;
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          flags_q <= flags_d;
          if (br_valid_i && br_taken) begin
            take_q  <= 1'b1;
            flush_q <= 1'b1;
            cnt_q   <= CNT_W'(FLUSH_CYCLES - 1);
            state_q <= FLUSH;
          end else begin
            take_q  <= 1'b0;
            flush_q <= 1'b0;
          end
        end
        FLUSH: begin
          take_q <= 1'b0;
          if (cnt_q == '0) begin
            flush_q <= 1'b0;
            state_q <= RUN;
          end else begin
            flush_q <= 1'b1;
            cnt_q   <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          take_q  <= 1'b0;
          flush_q <= 1'b0;
          state_q <= RUN;
        end
      endcase
    end
  end

  assign flags_o       = flags_q;
  assign take_branch_o = take_q;
  assign flush_o       = flush_q;

endmodule
